// File: rtl/player_anim_ctrl.sv
// Player sprite animation sequencer: vblank-synchronous throw/hit FSM driving frame_sel/frame_base.
// Optional hit flashing is enabled by defining PLAYER_HIT_FLASH_EN.
module player_anim_ctrl #(
   parameter int FRAME_PIXELS   = 24780,
   parameter int WINDUP_FRAMES  = 8,
   parameter int THROW_FRAMES   = 6,
   parameter int RECOVER_FRAMES = 10,
   parameter int HIT_FRAMES     = 30,
   parameter int FLASH_PERIOD   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        throw_req,
   input  logic        hit,
   output logic [1:0]  frame_sel,
   output logic [16:0] frame_base,
   output logic        sprite_visible,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WINDUP,
      S_THROW,
      S_RECOVER,
      S_HIT
   } state_t;

   if (FLASH_PERIOD < 1 || FLASH_PERIOD > 16 || (FLASH_PERIOD & (FLASH_PERIOD - 1)) != 0) begin : g_bad_flash
      $error("FLASH_PERIOD must be a power of two between 1 and 16");
   end

   state_t     state, state_n;
   logic [4:0] frame_cnt, cnt_n;
   logic       vblnk_p0, tick_p1;
   logic       throw_pend, hit_pend;
   logic       throw_clr, hit_clr, done_n, vis_n;

   function automatic logic [1:0] sel_of(input state_t s);
      case (s)
         S_WINDUP: sel_of = 2'd1;
         S_THROW:  sel_of = 2'd2;
         S_HIT:    sel_of = 2'd3;
         default:  sel_of = 2'd0;
      endcase
   endfunction

   function automatic logic [16:0] base_of(input logic [1:0] sel);
      base_of = 17'(int'(sel) * FRAME_PIXELS);
   endfunction

   // Next-state evaluation: only a tick may move the FSM or consume requests.
   always_comb begin
      state_n   = state;
      cnt_n     = frame_cnt;
      done_n    = 1'b0;
      throw_clr = 1'b0;
      hit_clr   = 1'b0;
      if (tick_p1) begin
         cnt_n = frame_cnt + 5'd1;
         if (state != S_HIT && hit_pend) begin
            state_n   = S_HIT;
            throw_clr = 1'b1;
            hit_clr   = 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (throw_pend) begin
                     state_n   = S_WINDUP;
                     throw_clr = 1'b1;
                  end
               end
               S_WINDUP: begin
                  if (frame_cnt == 5'(WINDUP_FRAMES - 1)) state_n = S_THROW;
               end
               S_THROW: begin
                  if (frame_cnt == 5'(THROW_FRAMES - 1)) state_n = S_RECOVER;
               end
               S_RECOVER: begin
                  if (frame_cnt == 5'(RECOVER_FRAMES - 1)) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end
               end
               S_HIT: begin
                  hit_clr = 1'b1;
                  if (frame_cnt == 5'(HIT_FRAMES - 1)) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end
               end
               default: state_n = S_IDLE;
            endcase
         end
         if (state_n != state) cnt_n = 5'd0;
      end
`ifdef PLAYER_HIT_FLASH_EN
      vis_n = (state_n == S_HIT) ? ~cnt_n[$clog2(FLASH_PERIOD)] : 1'b1;
`else
      vis_n = 1'b1;
`endif
   end

   // Registered vblank edge detect, state and outputs all launched from the next-state values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_p0       <= 1'b0;
         tick_p1        <= 1'b0;
         state          <= S_IDLE;
         frame_cnt      <= 5'd0;
         throw_pend     <= 1'b0;
         hit_pend       <= 1'b0;
         frame_sel      <= 2'd0;
         frame_base     <= 17'd0;
         sprite_visible <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         vblnk_p0       <= vblnk;
         tick_p1        <= vblnk & ~vblnk_p0;
         state          <= state_n;
         frame_cnt      <= cnt_n;
         frame_sel      <= sel_of(state_n);
         frame_base     <= base_of(sel_of(state_n));
         sprite_visible <= vis_n;
         busy           <= (state_n != S_IDLE);
         done           <= done_n;
         // A simultaneous hit discards the throw; new requests survive a same-cycle consume.
         throw_pend     <= (throw_pend & ~throw_clr) | (throw_req & ~hit);
         hit_pend       <= (hit_pend & ~hit_clr) | hit;
      end
   end

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Directed bench for player_anim_ctrl: throw/hit sequences, pending requests, flash pattern and async reset.
module tb_player_anim_ctrl;

   localparam int FP = 24780;
   localparam int FLASH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vblnk = 1'b0;
   logic        throw_req = 1'b0;
   logic        hit = 1'b0;
   logic [1:0]  frame_sel;
   logic [16:0] frame_base;
   logic        sprite_visible;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_snap;

   player_anim_ctrl dut (
      .clk(clk), .rst(rst), .vblnk(vblnk), .throw_req(throw_req), .hit(hit),
      .frame_sel(frame_sel), .frame_base(frame_base), .sprite_visible(sprite_visible),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One video frame: vblnk rises at a negedge, outputs have settled by the end of the high phase.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) vblnk = 1'b1;
         repeat (3) @(negedge clk);
         vblnk = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic pulse(input logic t, input logic h);
      @(negedge clk);
      throw_req = t;
      hit = h;
      @(negedge clk);
      throw_req = 1'b0;
      hit = 1'b0;
   endtask

   function automatic logic exp_vis(input int k);
`ifdef PLAYER_HIT_FLASH_EN
      exp_vis = ((k / FLASH) % 2) == 0;
`else
      exp_vis = 1'b1;
`endif
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sel", 32'(frame_sel), 0);
      chk("rst_base", 32'(frame_base), 0);
      chk("rst_vis", 32'(sprite_visible), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b1;

      frames(5);
      chk("idle_sel", 32'(frame_sel), 0);
      chk("idle_base", 32'(frame_base), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done_cnt", 32'(done_cnt), 0);

      // Full throw sequence.
      done_snap = done_cnt;
      pulse(1'b1, 1'b0);
      chk("pend_no_early", 32'(frame_sel), 0);
      frames(1);
      chk("windup_sel", 32'(frame_sel), 1);
      chk("windup_base", 32'(frame_base), FP);
      chk("windup_busy", 32'(busy), 1);
      frames(7);
      chk("windup_hold", 32'(frame_sel), 1);
      frames(1);
      chk("throw_sel", 32'(frame_sel), 2);
      chk("throw_base", 32'(frame_base), 2 * FP);
      frames(6);
      chk("recover_sel", 32'(frame_sel), 0);
      chk("recover_busy", 32'(busy), 1);
      frames(9);
      chk("recover_no_done", 32'(done_cnt - done_snap), 0);
      frames(1);
      chk("seq_done_cnt", 32'(done_cnt - done_snap), 1);
      chk("seq_idle_busy", 32'(busy), 0);

      // Hit during WINDUP tick 3, plus a redundant hit mid-HIT.
      pulse(1'b1, 1'b0);
      frames(4);
      chk("windup_t3", 32'(frame_sel), 1);
      done_snap = done_cnt;
      pulse(1'b0, 1'b1);
      frames(1);
      chk("hit_sel", 32'(frame_sel), 3);
      chk("hit_base", 32'(frame_base), 3 * FP);
      chk("hit_vis_0", 32'(sprite_visible), 32'(exp_vis(0)));
      for (int k = 1; k < 30; k++) begin
         if (k == 10) pulse(1'b0, 1'b1);
         frames(1);
         chk($sformatf("hit_sel_%0d", k), 32'(frame_sel), 3);
         chk($sformatf("hit_vis_%0d", k), 32'(sprite_visible), 32'(exp_vis(k)));
      end
      chk("hit_no_done", 32'(done_cnt - done_snap), 0);
      frames(1);
      chk("hit_exit_sel", 32'(frame_sel), 0);
      chk("hit_exit_vis", 32'(sprite_visible), 1);
      chk("hit_exit_busy", 32'(busy), 0);
      chk("hit_done_cnt", 32'(done_cnt - done_snap), 1);
      frames(1);
      chk("no_resume_busy", 32'(busy), 0);

      // throw_req during THROW is held until after return to IDLE.
      pulse(1'b1, 1'b0);
      frames(9);
      chk("t2_throw_sel", 32'(frame_sel), 2);
      pulse(1'b1, 1'b0);
      frames(16);
      chk("held_idle_sel", 32'(frame_sel), 0);
      chk("held_idle_busy", 32'(busy), 0);
      frames(1);
      chk("held_rewindup", 32'(frame_sel), 1);
      frames(24);
      chk("held_end_busy", 32'(busy), 0);

      // Async reset during HIT tick 12 drops a pending throw.
      pulse(1'b0, 1'b1);
      frames(13);
      chk("pre_rst_sel", 32'(frame_sel), 3);
      chk("pre_rst_vis", 32'(sprite_visible), 32'(exp_vis(12)));
      pulse(1'b1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_sel", 32'(frame_sel), 0);
      chk("arst_base", 32'(frame_base), 0);
      chk("arst_vis", 32'(sprite_visible), 1);
      chk("arst_busy", 32'(busy), 0);
      @(negedge clk) rst = 1'b1;
      frames(2);
      chk("arst_pend_dropped", 32'(busy), 0);
      pulse(1'b1, 1'b0);
      frames(1);
      chk("clean_windup", 32'(frame_sel), 1);
      frames(7);
      chk("clean_windup_hold", 32'(frame_sel), 1);
      frames(1);
      chk("clean_throw", 32'(frame_sel), 2);
      frames(16);
      chk("clean_end", 32'(busy), 0);

      // Simultaneous throw and hit: hit wins, throw discarded.
      pulse(1'b1, 1'b1);
      frames(1);
      chk("both_sel", 32'(frame_sel), 3);
      frames(30);
      chk("both_exit_sel", 32'(frame_sel), 0);
      frames(1);
      chk("both_throw_dropped", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
